// File: rtl/prog_mem_loader.sv
// Run-time loadable program store: combinational fetch port plus a byte-wide valid/ready load port.
// Optional trailing checksum byte is enabled by defining PROG_LOAD_CHECKSUM_EN.
module prog_mem_loader #(
    parameter int               AWIDTH    = 8,
    parameter int               DWIDTH    = 13,
    parameter int               DEPTH     = 256,
    parameter logic [DWIDTH-1:0] FILL_WORD = {DWIDTH{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [AWIDTH-1:0] ADDR,
    output logic [DWIDTH-1:0] DATA,
    input  logic              LOAD_START,
    input  logic [AWIDTH:0]   LOAD_LEN,
    input  logic [7:0]        LOAD_BYTE,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    output logic              CPU_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);
    localparam int BYTES = (DWIDTH + 7) / 8;
    localparam int BW    = BYTES * 8;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
    localparam logic [BIW-1:0]  LAST_B  = BIW'(BYTES - 1);

`ifdef PROG_LOAD_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
    localparam state_t S_END = S_CHECK;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [AWIDTH:0]   len_q, len_d;
    logic [AWIDTH:0]   ptr_q, ptr_d;
    logic [BIW-1:0]    bidx_q, bidx_d;
    logic [BW-1:0]     asm_q, asm_d;
    logic              ready_q, ready_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic [DWIDTH-1:0] wr_word;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]     rd_idx;
`ifdef PROG_LOAD_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign rd_idx = ADDR[IW-1:0];
    assign DATA   = ({1'b0, ADDR} < DEPTH_W) ? mem_q[rd_idx] : FILL_WORD;

    // The final byte is placed before the write, so the word lands on the same edge it completes.
    assign wr_word = asm_d[DWIDTH-1:0];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        wr_en   = 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (LOAD_START) begin
                    len_d  = (LOAD_LEN > DEPTH_W) ? DEPTH_W : LOAD_LEN;
                    ptr_d  = '0;
                    bidx_d = '0;
                    asm_d  = '0;
`ifdef PROG_LOAD_CHECKSUM_EN
                    sum_d  = '0;
                    err_d  = 1'b0;
`endif
                    state_d = (len_d == '0) ? S_END : S_LOAD;
                end
            end
            S_LOAD: begin
                if (LOAD_VALID) begin
                    asm_d[{bidx_q, 3'b000} +: 8] = LOAD_BYTE;
`ifdef PROG_LOAD_CHECKSUM_EN
                    sum_d = sum_q + LOAD_BYTE;
`endif
                    if (bidx_q == LAST_B) begin
                        wr_en  = 1'b1;
                        bidx_d = '0;
                        ptr_d  = ptr_q + 1'b1;
                        if (ptr_q == len_q - 1'b1) state_d = S_END;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
`ifdef PROG_LOAD_CHECKSUM_EN
            S_CHECK: begin
                if (LOAD_VALID) begin
                    err_d   = (LOAD_BYTE != sum_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef PROG_LOAD_CHECKSUM_EN
        ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
        ready_d = (state_d == S_LOAD);
`endif
        hold_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL_WORD;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
`ifdef PROG_LOAD_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
            if (wr_en) mem_q[ptr_q[IW-1:0]] <= wr_word;
        end
    end

    assign LOAD_READY = ready_q;
    assign CPU_HOLD   = hold_q;
    assign LOAD_DONE  = done_q;
`ifdef PROG_LOAD_CHECKSUM_EN
    assign LOAD_ERR   = err_q;
`else
    assign LOAD_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: stimulus queues expected values, a negedge monitor checks them.
module tb_prog_mem_loader;
    localparam int AW = 8;
    localparam int DW = 13;
    localparam logic [DW-1:0] FILL = 13'h1ABC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data, data4;
    logic          load_start = 1'b0, load_start4 = 1'b0;
    logic [AW:0]   load_len = '0;
    logic [7:0]    load_byte = '0;
    logic          load_valid = 1'b0;
    logic          ready, hold, done, err;
    logic          ready4, hold4, done4, err4;

    always #5 clk = ~clk;

    prog_mem_loader #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(256), .FILL_WORD(FILL)) dut (
        .CLK(clk), .RST(rst), .ADDR(addr), .DATA(data),
        .LOAD_START(load_start), .LOAD_LEN(load_len), .LOAD_BYTE(load_byte),
        .LOAD_VALID(load_valid), .LOAD_READY(ready), .CPU_HOLD(hold),
        .LOAD_DONE(done), .LOAD_ERR(err));

    prog_mem_loader #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(4), .FILL_WORD(FILL)) dut4 (
        .CLK(clk), .RST(rst), .ADDR(addr), .DATA(data4),
        .LOAD_START(load_start4), .LOAD_LEN(load_len), .LOAD_BYTE(load_byte),
        .LOAD_VALID(load_valid), .LOAD_READY(ready4), .CPU_HOLD(hold4),
        .LOAD_DONE(done4), .LOAD_ERR(err4));

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    localparam int SEL_DATA = 0, SEL_HOLD = 1, SEL_READY = 2, SEL_ERR = 3, SEL_DONE = 4;
    localparam int SEL_DATA4 = 5, SEL_HOLD4 = 6, SEL_READY4 = 7;

    chk_t        chk_q[$];
    logic        done_exp_q[$];
    logic        done4_exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          sample = 1'b0;
    bit          fin = 1'b0;

    logic [DW-1:0] model  [256];
    logic [DW-1:0] model4 [4];
    logic [7:0]    bbuf [16];
    int            gbuf [16];
    int            mid_start = -1;

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            SEL_DATA:   return 32'(data);
            SEL_HOLD:   return 32'(hold);
            SEL_READY:  return 32'(ready);
            SEL_ERR:    return 32'(err);
            SEL_DONE:   return 32'(done);
            SEL_DATA4:  return 32'(data4);
            SEL_HOLD4:  return 32'(hold4);
            SEL_READY4: return 32'(ready4);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (done_exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got LOAD_DONE=1 expected 0");
            end else begin
                logic e;
                e = done_exp_q.pop_front();
                if (err !== e || hold !== 1'b1 || ready !== 1'b0) begin
                    errors++;
                    $display("FAIL done_status: got err=%0b hold=%0b ready=%0b expected err=%0b hold=1 ready=0",
                             err, hold, ready, e);
                end
            end
        end
        if (done4) begin
            checks++;
            if (done4_exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done4: got LOAD_DONE=1 expected 0");
            end else begin
                logic e;
                e = done4_exp_q.pop_front();
                if (err4 !== e || hold4 !== 1'b1 || ready4 !== 1'b0) begin
                    errors++;
                    $display("FAIL done4_status: got err=%0b hold=%0b ready=%0b expected err=%0b hold=1 ready=0",
                             err4, hold4, ready4, e);
                end
            end
        end
        if (sample) begin
            while (chk_q.size() > 0) begin
                chk_t c;
                logic [31:0] g;
                c = chk_q.pop_front();
                g = get_sig(c.sel);
                checks++;
                if (g !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", c.name, g, c.exp);
                end
            end
        end
        if (fin) begin
            checks++;
            if (done_exp_q.size() != 0 || done4_exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_done: got %0d/%0d pending pulses expected 0/0",
                         done_exp_q.size(), done4_exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic probe();
        sample = 1'b1;
        @(negedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic status(input string tag, input logic h, input logic r, input logic d);
        expect_sig({tag, "_hold"},  SEL_HOLD,  32'(h));
        expect_sig({tag, "_ready"}, SEL_READY, 32'(r));
        expect_sig({tag, "_done"},  SEL_DONE,  32'(d));
        probe();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 256; a++) begin
            addr = AW'(a);
            expect_sig($sformatf("%s_a%02h", tag, a), SEL_DATA, 32'(model[a]));
            expect_sig($sformatf("%s_d4_a%02h", tag, a), SEL_DATA4,
                       (a < 4) ? 32'(model4[a]) : 32'(FILL));
            probe();
        end
    endtask

    // Data bytes come from bbuf/gbuf; cs is the trailing checksum byte when that feature is built.
    task automatic do_load(input bit to4, input logic [AW:0] len, input int nb,
                           input logic [7:0] cs, input logic exp_err);
        logic e;
`ifdef PROG_LOAD_CHECKSUM_EN
        e = exp_err;
`else
        e = 1'b0;
`endif
        if (to4) done4_exp_q.push_back(e);
        else     done_exp_q.push_back(e);
        @(posedge clk); #1;
        load_len = len;
        if (to4) load_start4 = 1'b1;
        else     load_start  = 1'b1;
        @(posedge clk); #1;
        load_start  = 1'b0;
        load_start4 = 1'b0;
        for (int i = 0; i < nb; i++) begin
            load_byte  = bbuf[i];
            load_valid = 1'b1;
            if (i == mid_start) begin
                load_start = 1'b1;
                load_len   = 9'd1;
            end
            if (i == 0) begin
                expect_sig("hold_in_load",  to4 ? SEL_HOLD4 : SEL_HOLD, 32'd1);
                expect_sig("ready_in_load", to4 ? SEL_READY4 : SEL_READY, 32'd1);
                probe();
            end
            @(posedge clk); #1;
            load_valid = 1'b0;
            load_start = 1'b0;
            for (int g = 0; g < gbuf[i]; g++) begin
                @(posedge clk); #1;
            end
        end
`ifdef PROG_LOAD_CHECKSUM_EN
        load_byte  = cs;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
`else
        load_byte = cs;
`endif
    endtask

    task automatic set_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5, input int gap);
        bbuf[0] = b0; bbuf[1] = b1; bbuf[2] = b2; bbuf[3] = b3; bbuf[4] = b4; bbuf[5] = b5;
        for (int i = 0; i < 16; i++) gbuf[i] = gap;
        gbuf[5] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) model[i] = FILL;
        for (int i = 0; i < 4; i++) model4[i] = FILL;
        for (int i = 0; i < 16; i++) begin bbuf[i] = 8'h00; gbuf[i] = 0; end

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        status("reset", 1'b0, 1'b0, 1'b0);
        expect_sig("reset_err", SEL_ERR, 32'd0);
        expect_sig("reset_hold4", SEL_HOLD4, 32'd0);
        expect_sig("reset_ready4", SEL_READY4, 32'd0);
        probe();
        sweep("rst");

        // Basic load, then one cycle later the core is released.
        set_bytes(8'hAE, 8'h05, 8'h04, 8'h07, 8'h11, 8'h0A, 0);
        do_load(1'b0, 9'd3, 6, 8'hD9, 1'b0);
        @(posedge clk); #1;
        status("after_basic", 1'b0, 1'b0, 1'b0);
        model[0] = 13'h05AE; model[1] = 13'h0704; model[2] = 13'h0A11;
        sweep("basic");

        // Overwrite with different words; the last byte's upper bits must be dropped.
        set_bytes(8'h34, 8'hF2, 8'h00, 8'h00, 8'hFF, 8'h1F, 0);
        do_load(1'b0, 9'd3, 6, 8'h44, 1'b0);
        model[0] = 13'h1234; model[1] = 13'h0000; model[2] = 13'h1FFF;
        sweep("ovr");

        // Back-pressure: VALID pattern 1,0,0,1 between bytes.
        set_bytes(8'hAE, 8'h05, 8'h04, 8'h07, 8'h11, 8'h0A, 2);
        do_load(1'b0, 9'd3, 6, 8'hD9, 1'b0);
        model[0] = 13'h05AE; model[1] = 13'h0704; model[2] = 13'h0A11;
        sweep("bp");

        // Zero-length load: pulse only, nothing written.
        do_load(1'b0, 9'd0, 0, 8'h00, 1'b0);
        @(posedge clk); #1;
        status("after_len0", 1'b0, 1'b0, 1'b0);

        // Second START during LOAD is ignored; words past len keep old contents.
        set_bytes(8'h55, 8'h00, 8'h66, 8'h01, 8'h00, 8'h00, 0);
        mid_start = 1;
        do_load(1'b0, 9'd2, 4, 8'hBC, 1'b0);
        mid_start = -1;
        model[0] = 13'h0055; model[1] = 13'h0166;
        sweep("midstart");

        // Clamp on a 4-deep store with LOAD_LEN=9.
        for (int i = 0; i < 4; i++) begin bbuf[2*i] = 8'(i + 1); bbuf[2*i+1] = 8'h00; end
        for (int i = 0; i < 16; i++) gbuf[i] = 0;
        do_load(1'b1, 9'd9, 8, 8'h0A, 1'b0);
        model4[0] = 13'h0001; model4[1] = 13'h0002; model4[2] = 13'h0003; model4[3] = 13'h0004;
        sweep("clamp");

`ifdef PROG_LOAD_CHECKSUM_EN
        set_bytes(8'h12, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        do_load(1'b0, 9'd1, 2, 8'h13, 1'b0);
        model[0] = 13'h0112;
        expect_sig("cs_good_err", SEL_ERR, 32'd0);
        expect_sig("cs_good_word", SEL_DATA, 32'h0112);
        addr = 8'h00;
        probe();
        do_load(1'b0, 9'd1, 2, 8'h14, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        expect_sig("cs_bad_err_held", SEL_ERR, 32'd1);
        expect_sig("cs_bad_word_kept", SEL_DATA, 32'h0112);
        probe();
        @(posedge clk); #1;
        load_len   = 9'd0;
        load_start = 1'b1;
        done_exp_q.push_back(1'b0);
        @(posedge clk); #1;
        load_start = 1'b0;
        expect_sig("cs_err_cleared", SEL_ERR, 32'd0);
        expect_sig("cs_len0_ready", SEL_READY, 32'd1);
        probe();
        load_byte  = 8'h00;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
`else
        expect_sig("err_tied_low", SEL_ERR, 32'd0);
        probe();
`endif

        // Reset after 3 of 6 bytes: no done pulse, memory back to fill, FSM idle.
        @(posedge clk); #1;
        load_len   = 9'd3;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_byte  = 8'h21 + 8'(i);
            load_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        status("after_rst_mid", 1'b0, 1'b0, 1'b0);
        load_valid = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = FILL;
        for (int i = 0; i < 4; i++) model4[i] = FILL;
        sweep("rstmid");
        status("idle_after_rst", 1'b0, 1'b0, 1'b0);

        fin = 1'b1;
    end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised, run-time loadable program memory for the one-cycle CPU.
- Replaces the fixed, hard-coded program store.
- Fetch port is combinational, so the CPU still fetches and executes in one cycle.
- A byte-wide valid/ready load port writes a new program from address 0 while CPU_HOLD stalls the core.

Parameters:
- AWIDTH, 8, fetch/write address width.
- DWIDTH, 13, instruction word width (opcode + 8-bit operand).
- DEPTH, 256, number of words; must be <= 2**AWIDTH.
- FILL_WORD, {DWIDTH{1'b0}}, word returned for unwritten/out-of-range locations; CPU top sets it to the RST instruction encoding.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  synchronous active-high reset.
- ADDR  input  AWIDTH  CPU fetch address.
- DATA  output  DWIDTH  instruction at ADDR, combinational.
- LOAD_START  input  1  pulse: begin load of LOAD_LEN words.
- LOAD_LEN  input  AWIDTH+1  word count, sampled with LOAD_START.
- LOAD_BYTE  input  8  load data byte.
- LOAD_VALID  input  1  LOAD_BYTE valid.
- LOAD_READY  output  1  loader accepts a byte this cycle.
- CPU_HOLD  output  1  high while loading; CPU must not advance PC.
- LOAD_DONE  output  1  one-cycle pulse at end of load.
- LOAD_ERR  output  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Clocking and reset: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset values:
  - All DEPTH words are set to FILL_WORD.
  - FSM goes to IDLE.
  - LOAD_READY=0, CPU_HOLD=0, LOAD_DONE=0, LOAD_ERR=0.
  - Word pointer, byte index and assembly register are cleared.
- Fetch:
  - DATA = mem[ADDR] when ADDR < DEPTH, else FILL_WORD.
  - Purely combinational, zero latency.
  - A word written on edge N is visible on DATA after edge N.
- Byte packing:
  - BYTES = ceil(DWIDTH/8); 2 for the defaults.
  - Bytes arrive least-significant first: byte k carries word bits [8k+7:8k].
  - Bits of the last byte above DWIDTH are ignored.
- FSM states: IDLE, LOAD, CHECK, DONE.
  - IDLE: LOAD_READY=0, CPU_HOLD=0.
    - On LOAD_START, latch len = min(LOAD_LEN, DEPTH) and clear the pointer, byte index and LOAD_ERR.
    - If len==0, go to DONE; otherwise go to LOAD.
  - LOAD: LOAD_READY=1, CPU_HOLD=1. A transfer occurs on an edge where LOAD_VALID && LOAD_READY.
    - Each transfer shifts the byte into the assembly register and increments the byte index.
    - On the BYTES-th byte, write the assembled word to mem[ptr] on that same edge, then ptr++ and byte index=0.
    - After word len-1 is written, go to CHECK (feature enabled) or DONE.
    - LOAD_VALID low stalls the FSM with no state change.
  - CHECK: see Optional Feature. Without the feature, this state is unreachable.
  - DONE: CPU_HOLD=1, LOAD_READY=0, LOAD_DONE=1 for exactly one cycle, then IDLE.
- LOAD_START outside IDLE is ignored.
- Words at addresses >= len keep their previous contents; there is no auto-clear on load.
- LOAD_LEN > DEPTH is clamped to DEPTH. The loader never writes at or beyond DEPTH.
- RST mid-load aborts the load: memory goes to FILL_WORD, FSM to IDLE, and no LOAD_DONE pulse.
- RST has priority over every other input on the same edge.
- LOAD_ERR is held until the next LOAD_START or RST.

Optional Feature:
- Macro: PROG_LOAD_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of every accepted data byte is kept, cleared at LOAD_START.
  - After the last word, the FSM enters CHECK with LOAD_READY=1 and accepts one more byte as the checksum.
  - If that byte != the running sum, LOAD_ERR=1. Memory contents are kept either way.
  - The FSM then goes to DONE. The len==0 case goes through CHECK as well.
- Not defined: no CHECK state, no sum register, LOAD_ERR tied to 0.

Test Plan:
- Reset then read:
  - Stimulus: RST high one cycle, then sweep ADDR 0x00..0xFF.
  - Response: DATA==FILL_WORD everywhere; CPU_HOLD=0, LOAD_READY=0.
- Basic load:
  - Stimulus: LOAD_START with LOAD_LEN=3, then bytes AE,05, 04,07, 11,0A with VALID continuously high.
  - Response: CPU_HOLD=1 from the cycle after START; six transfers.
  - Result: mem[0]=0x5AE, mem[1]=0x704, mem[2]=0xA11; LOAD_DONE pulses once; CPU_HOLD=0 the following cycle.
- Back-pressure:
  - Stimulus: same load as above, with LOAD_VALID toggling 1,0,0,1 between bytes.
  - Response: identical memory result; no write while VALID=0.
- Boundaries:
  - LOAD_LEN=0: DONE pulse one cycle after START, and no write.
  - DEPTH=4 with LOAD_LEN=9: exactly 4 words written, then DONE; ADDR=4..255 reads FILL_WORD.
- Reset mid-load:
  - Stimulus: RST asserted after 3 of 6 bytes.
  - Response: mem[0] is back to FILL_WORD, state is IDLE, LOAD_DONE never asserts.
  - A second LOAD_START issued during LOAD is ignored.
- Checksum (with PROG_LOAD_CHECKSUM_EN):
  - LOAD_LEN=1 with bytes 12,01 then checksum 13: LOAD_ERR=0.
  - Same bytes with checksum 14: LOAD_ERR=1, held until the next LOAD_START.
